// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - N-channel registered mux with manual select and auto-scan dwell
module mux_scan_nx1 #(
  parameter  int N_CH    = 16,
  parameter  int DATA_W  = 1,
  parameter  int DWELL_W = 8,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   din,
  input  logic                     en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [DATA_W-1:0]        dout,
  output logic [SEL_W-1:0]         ch,
  output logic                     valid,
  output logic                     wrap
);

  typedef enum logic { MANUAL, SCAN } state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]    dout_d;
  logic [SEL_W-1:0]     ch_d;
  logic                 valid_d, wrap_d;
  logic [SEL_W-1:0]     cur_ptr;
  logic [DWELL_W-1:0]   cur_cnt;
  logic                 sel_in_range;

  function automatic logic [DATA_W-1:0] pick(input logic [N_CH*DATA_W-1:0] bus,
                                             input logic [SEL_W-1:0] idx);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) r = bus[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // N_CH need not be a power of two, so the top select codes are illegal
  assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(N_CH));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    dout_d  = dout;
    ch_d    = ch;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    cur_ptr = '0;
    cur_cnt = '0;
    if (en) begin
      if (mode) begin
        // Scan entry always restarts at channel 0 regardless of stale ptr/cnt
        if (state_q == SCAN) begin
          cur_ptr = ptr_q;
          cur_cnt = cnt_q;
        end
        state_d = SCAN;
        ch_d    = cur_ptr;
        dout_d  = pick(din, cur_ptr);
        valid_d = 1'b1;
        if (cur_cnt >= dwell) begin
          cnt_d  = '0;
          ptr_d  = (cur_ptr == LAST_CH) ? '0 : cur_ptr + 1'b1;
          wrap_d = (cur_ptr == LAST_CH);
        end else begin
          ptr_d  = cur_ptr;
          cnt_d  = cur_cnt + 1'b1;
        end
      end else begin
        state_d = MANUAL;
        ch_d    = sel;
        if (sel_in_range) begin
          dout_d  = pick(din, sel);
          valid_d = 1'b1;
        end else begin
          dout_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      dout  <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      dout  <= dout_d;
      ch    <= ch_d;
      valid <= valid_d;
      wrap  <= wrap_d;
    end
  end

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised N-channel, W-bit registered multiplexer with two modes: manual select, and auto-scan that steps through all channels with a programmable dwell time. It generalises the 16x1 combinational mux family. It is the front-end selector for multi-channel sampling paths, where downstream logic consumes one registered sample stream tagged with its channel index.

## Interface
- N_CH, 16, number of input channels, ≥2, need not be a power of two
- DATA_W, 1, width of each channel in bits
- DWELL_W, 8, width of the dwell-count input
- SEL_W (localparam), clog2(N_CH), width of the select and channel-index fields
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  N_CH*DATA_W  packed channel data; channel k is din[k*DATA_W +: DATA_W]
- en  input  1  enable; when low, all state and outputs freeze
- mode  input  1  0 = manual select, 1 = auto-scan
- sel  input  SEL_W  manual channel select
- dwell  input  DWELL_W  cycles per channel in scan mode, minus 1
- dout  output  DATA_W  registered selected data
- ch  output  SEL_W  channel index of dout
- valid  output  1  dout/ch hold a legal sample this cycle
- wrap  output  1  one-cycle pulse on the last sample of channel N_CH-1 in scan mode

## Operation
- State machine has two states: MANUAL (reset state) and SCAN. Internal registers: ptr (SEL_W) and cnt (DWELL_W).
- Reset (asynchronous): dout=0, ch=0, valid=0, wrap=0, ptr=0, cnt=0, state=MANUAL.
- en=0: state, ptr, cnt, dout and ch hold. valid<=0, wrap<=0.
- MANUAL with en=1, mode=0: ch<=sel, wrap<=0.
  - If sel<N_CH: dout<=din[sel], valid<=1.
  - If sel≥N_CH: dout<=0, valid<=0.
- MANUAL with en=1, mode=1 (scan entry): go to SCAN. This cycle is the first scan cycle with ptr=0 and cnt=0. The previous ptr/cnt values are ignored.
- SCAN with en=1, mode=1, each cycle:
  - ch<=ptr, dout<=din[ptr], valid<=1. Data is re-sampled live on every dwell cycle.
  - If cnt≥dwell: cnt<=0 and ptr advances, wrapping N_CH-1→0. wrap<=1 iff ptr==N_CH-1.
  - Otherwise: cnt<=cnt+1, wrap<=0.
- The dwell compare is ≥, so lowering dwell mid-channel advances on the next cycle. Raising it extends the current channel.
- SCAN with en=1, mode=0: go to MANUAL. That cycle produces the manual output as above. ptr/cnt are not cleared, but re-entry to SCAN always restarts at channel 0.
- sel is ignored in SCAN. dwell is ignored in MANUAL.

## Timing
- Latency is 1 cycle from din/sel to dout/ch/valid in both modes. There is no combinational input-to-output path.
- In SCAN, each channel is presented for exactly dwell+1 consecutive enabled cycles. A full sweep takes N_CH*(dwell+1) enabled cycles.
- wrap is high for exactly one cycle, coincident with the final dout sample of channel N_CH-1. At dwell=0 with N_CH=2, wrap is high every other cycle.
- en deassertion mid-dwell pauses cnt. On resume, the remaining dwell cycles complete with no cycle lost or repeated.
- Reset asserted mid-scan forces all outputs to 0 immediately, without waiting for clk. After release, the block is in MANUAL. The first output appears on the first enabled edge.
- Mode change takes effect on the same edge it is sampled.

## Test plan
- Manual one-hot walk, N_CH=16, DATA_W=1: for s=15..0 apply sel=s, din=1<<s, en=1, mode=0 -> one cycle later dout=1, ch=s, valid=1. Repeat with din=~(1<<s) -> dout=0.
- Scan with N_CH=5, DATA_W=8, din[k]=8'h10+k, dwell=2, mode 0→1 -> ch sequence 0,0,0,1,1,1,…,4,4,4,0. dout matches 8'h10+ch. wrap=1 only on the third cycle of ch=4, i.e. the 15th scan cycle.
- Dwell change: dwell=3, and at cnt=2 on ch=1 set dwell=1 -> ch advances to 2 on the next cycle. Channel 2 then lasts 2 cycles.
- Out-of-range select, N_CH=5: sel=6 -> dout=0, valid=0, ch=6. Then sel=4 -> dout=din[4], valid=1.
- Enable freeze: scanning at dwell=3, drop en for 4 cycles on the 2nd cycle of ch=2 -> dout/ch hold and valid=0. After en returns, ch=2 persists for exactly 2 more cycles, then becomes 3.
- Reset mid-scan: assert rst_n=0 between clock edges while ch=3 -> all outputs are 0 before the next edge. After release with mode=1, scan restarts at ch=0.
